// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache with round-robin replacement.
// Optional DCACHE_STATS_EN adds saturating hit/miss/writeback counters.
module dcache_assoc #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 16,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = $clog2(LINE_W / DATA_W);
  localparam int unsigned DW_LOG = $clog2(DATA_W);
  localparam int unsigned BIT_W  = $clog2(LINE_W);
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB, ALLOC, FILL} state_t;

  state_t state, state_n;

  logic [LINE_W-1:0] data_arr [WAYS][SETS];
  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic              valid    [WAYS][SETS];
  logic              dirty    [WAYS][SETS];
  logic [WAY_W-1:0]  vptr     [SETS];

  logic [LINE_W-1:0] fill_line;
  logic [WAY_W-1:0]  vic_way, vic_way_n;
  logic              vic_inv, vic_inv_n;
  logic              en_n, wr_n;
  logic [ADDR_W-1:0] addr_n;
  logic [LINE_W-1:0] mdata_n;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [BIT_W-1:0]  woff;
  logic              req, hit, inv_found, access_ok;
  logic [WAY_W-1:0]  hit_way, inv_way, victim;
  logic [LINE_W-1:0] hit_line;
  logic              addr_unused;

  assign idx  = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel = p1_addr_i[OFF_W-1 -: WSEL_W];
  assign woff = {wsel, {DW_LOG{1'b0}}};
  assign req  = p1_MemRead_i | p1_MemWrite_i;
  assign addr_unused = ^p1_addr_i[OFF_W-WSEL_W-1:0];

  // Tag compare across all ways; lowest-index invalid way is the preferred victim.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][idx] && (tag_arr[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[w][idx] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim    = inv_found ? inv_way : vptr[idx];
  assign hit_line  = data_arr[hit_way][idx];
  assign access_ok = (state == IDLE) && req && hit;
  assign p1_stall_o = (state != IDLE) || (req && !hit);
  assign p1_data_o  = (access_ok && p1_MemRead_i) ? hit_line[woff +: DATA_W] : '0;

  // Miss sequencing; memory request fields are registered and held until ack.
  always_comb begin
    state_n   = state;
    en_n      = mem_enable_o;
    wr_n      = mem_write_o;
    addr_n    = mem_addr_o;
    mdata_n   = mem_data_o;
    vic_way_n = vic_way;
    vic_inv_n = vic_inv;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          vic_way_n = victim;
          vic_inv_n = inv_found;
          en_n      = 1'b1;
          if (valid[victim][idx] && dirty[victim][idx]) begin
            state_n = WB;
            wr_n    = 1'b1;
            addr_n  = {tag_arr[victim][idx], idx, {OFF_W{1'b0}}};
            mdata_n = data_arr[victim][idx];
          end else begin
            state_n = ALLOC;
            wr_n    = 1'b0;
            addr_n  = {tag, idx, {OFF_W{1'b0}}};
          end
        end
      end
      WB: begin
        if (mem_ack_i) begin
          state_n = ALLOC;
          en_n    = 1'b0;
          wr_n    = 1'b0;
          addr_n  = {tag, idx, {OFF_W{1'b0}}};
        end
      end
      ALLOC: begin
        // Enable is low for one cycle after a writeback ack, then re-raised.
        if (!mem_enable_o) begin
          en_n = 1'b1;
        end else if (mem_ack_i) begin
          en_n    = 1'b0;
          state_n = FILL;
        end
      end
      FILL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      vic_way      <= '0;
      vic_inv      <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid[w][s] <= 1'b0;
          dirty[w][s] <= 1'b0;
        end
      end
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else begin
      state        <= state_n;
      mem_enable_o <= en_n;
      mem_write_o  <= wr_n;
      mem_addr_o   <= addr_n;
      mem_data_o   <= mdata_n;
      vic_way      <= vic_way_n;
      vic_inv      <= vic_inv_n;
      if (access_ok && p1_MemWrite_i) dirty[hit_way][idx] <= 1'b1;
      if (state == FILL) begin
        valid[vic_way][idx] <= 1'b1;
        dirty[vic_way][idx] <= 1'b0;
        if (!vic_inv) vptr[idx] <= (WAYS > 1) ? vptr[idx] + WAY_W'(1) : '0;
      end
    end
  end

  // Line and tag storage; contents are only meaningful where valid is set.
  always_ff @(posedge clk_i) begin
    if ((state == ALLOC) && mem_enable_o && mem_ack_i) fill_line <= mem_data_i;
    if (access_ok && p1_MemWrite_i) data_arr[hit_way][idx][woff +: DATA_W] <= p1_data_i;
    if (state == FILL) begin
      data_arr[vic_way][idx] <= fill_line;
      tag_arr[vic_way][idx]  <= tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay;

  // Replay hit after a fill belongs to the miss, not to the hit count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      replay     <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      replay <= (state == FILL);
      if (access_ok && !replay && (hit_cnt_o != '1)) hit_cnt_o <= hit_cnt_o + 32'd1;
      if ((state == IDLE) && req && !hit && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 32'd1;
      if ((state == WB) && mem_ack_i && (wb_cnt_o != '1)) wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule
